// File: rtl/oaram_writer.sv
// oaram_writer: zero-run-length compresses a stream of post-ReLU activations
// into (value, zero-count) entries and writes them to the output activation RAM.
// Channel groups are delimited by in_last; the write pointer persists across groups.
module oaram_writer #(
  parameter int RAM_WIDTH   = 10,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_value,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [7:0]             oaram_value,
  output logic [INDEX_WIDTH-1:0] oaram_indices_value,
  output logic [RAM_WIDTH-1:0]   oaram_address,
  output logic                   oaram_write_enable,
  output logic                   group_done,
  output logic [RAM_WIDTH:0]     group_entry_count,
  output logic                   oaram_full
);

  localparam logic [INDEX_WIDTH-1:0] MAXRUN = '1;

  typedef enum logic {RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] zrun_q, zrun_d;
  logic [RAM_WIDTH-1:0]   ptr_q, ptr_d;
  logic [RAM_WIDTH:0]     count_q, count_d;
  logic                   full_q, full_d;
  logic [7:0]             value_q, value_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [RAM_WIDTH-1:0]   addr_q, addr_d;
  logic                   we_q, we_d;

  logic accept;
  logic emit;

  // Next-state: run-length tracking, entry emission, pointer/count/full, group FSM
  always_comb begin
    state_d = state_q;
    zrun_d  = zrun_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    full_d  = full_q;
    value_d = value_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    we_d    = 1'b0;

    accept = in_valid && (state_q == RUN);
    // A zero at max run emits value 0 with idx = zrun_q = MAXRUN,
    // so nonzero entries and max-run zero entries share the same write path.
    emit   = accept && ((in_value != 8'd0) || (zrun_q == MAXRUN));

    unique case (state_q)
      RUN: begin
        if (emit) begin
          zrun_d = '0;
          if (!full_q) begin
            we_d    = 1'b1;
            value_d = in_value;
            idx_d   = zrun_q;
            addr_d  = ptr_q;
            count_d = count_q + (RAM_WIDTH+1)'(1);
            if (ptr_q == '1) full_d = 1'b1;
            else             ptr_d  = ptr_q + RAM_WIDTH'(1);
          end
        end else if (accept) begin
          zrun_d = zrun_q + INDEX_WIDTH'(1);
        end
        if (accept && in_last) begin
          zrun_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        count_d = '0;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State and registered RAM-side outputs, all cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      zrun_q  <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      value_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      zrun_q  <= zrun_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      value_q <= value_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
    end
  end

  // in_ready is gated by reset_n so it reads 0 while reset is held
  assign in_ready            = reset_n && (state_q == RUN);
  assign group_done          = (state_q == DONE);
  assign group_entry_count   = group_done ? count_q : '0;
  assign oaram_value         = value_q;
  assign oaram_indices_value = idx_q;
  assign oaram_address       = addr_q;
  assign oaram_write_enable  = we_q;
  assign oaram_full          = full_q;

endmodule
